// File: rtl/period_scan_ctrl.sv
// period_scan_ctrl: round-robin period measurement of CHANNELS asynchronous clocks with one
// shared cycle counter, plus per-channel lock (period stability) and sticky timeout flags.
module period_scan_ctrl #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned TIMEOUT      = 1000,
    parameter int unsigned TOLERANCE    = 1,
    parameter int unsigned STABLE_COUNT = 3,
    localparam int unsigned SelW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          RST,
    input  logic                          PWRDWN,
    input  logic                          enable,
    input  logic [CHANNELS-1:0]           sig_in,
    output logic [SelW-1:0]               sel,
    output logic                          busy,
    output logic                          done,
    output logic [CHANNELS*CNT_WIDTH-1:0] period_out,
    output logic [CHANNELS-1:0]           period_valid,
    output logic [CHANNELS-1:0]           locked,
    output logic [CHANNELS-1:0]           timeout_err
);

    localparam int unsigned          StW      = (STABLE_COUNT > 0) ? $clog2(STABLE_COUNT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] TimeoutC = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] TolC     = CNT_WIDTH'(TOLERANCE);
    localparam logic [StW-1:0]       StableC  = StW'(STABLE_COUNT);
    localparam logic [SelW-1:0]      SelLast  = SelW'(CHANNELS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StMeasure,
        StStore,
        StTmo,
        StNext
    } state_e;

    state_e                             state_q, state_d;
    logic [SelW-1:0]                    sel_q, sel_d;
    logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;
    logic                               done_q, done_d;
    logic [CHANNELS-1:0][CNT_WIDTH-1:0] period_q, period_d;
    logic [CHANNELS-1:0]                valid_q, valid_d;
    logic [CHANNELS-1:0]                tmo_q, tmo_d;
    logic [CHANNELS-1:0][StW-1:0]       stable_q, stable_d;
    logic [CHANNELS-1:0]                s1_q, s2_q, s3_q;

    logic [CHANNELS-1:0]  rise;
    logic                 rise_sel;
    logic [CNT_WIDTH-1:0] cur_period;
    logic [CNT_WIDTH-1:0] diff;

    // Three-flop synchroniser; edge taken between the 2nd and 3rd stage.
    assign rise     = s2_q & ~s3_q;
    assign rise_sel = rise[sel_q];

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        period_d   = period_q;
        valid_d    = valid_q;
        tmo_d      = tmo_q;
        stable_d   = stable_q;
        cur_period = period_q[sel_q];
        diff       = (cnt_q >= cur_period) ? (cnt_q - cur_period) : (cur_period - cnt_q);

        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StArm;
                    cnt_d   = '0;
                end
            end
            StArm: begin
                if (rise_sel) begin
                    state_d = StMeasure;
                    cnt_d   = CNT_WIDTH'(1);
                end else if (cnt_q == TimeoutC) begin
                    state_d = StTmo;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StMeasure: begin
                // A rise exactly at the timeout boundary still yields a valid period.
                if (rise_sel) begin
                    state_d = StStore;
                end else if (cnt_q == TimeoutC) begin
                    state_d = StTmo;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStore: begin
                if (valid_q[sel_q] && (diff <= TolC)) begin
                    if (stable_q[sel_q] != StableC) begin
                        stable_d[sel_q] = stable_q[sel_q] + 1'b1;
                    end
                end else begin
                    stable_d[sel_q] = '0;
                end
                period_d[sel_q] = cnt_q;
                valid_d[sel_q]  = 1'b1;
                done_d          = 1'b1;
                state_d         = StNext;
            end
            StTmo: begin
                period_d[sel_q] = '0;
                valid_d[sel_q]  = 1'b0;
                stable_d[sel_q] = '0;
                tmo_d[sel_q]    = 1'b1;
                done_d          = 1'b1;
                state_d         = StNext;
            end
            StNext: begin
                sel_d   = (sel_q == SelLast) ? '0 : (sel_q + 1'b1);
                cnt_d   = '0;
                state_d = enable ? StArm : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST || PWRDWN) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            period_q <= '0;
            valid_q  <= '0;
            tmo_q    <= '0;
            stable_q <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            tmo_q    <= tmo_d;
            stable_q <= stable_d;
            s1_q     <= sig_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
        end
    end

    always_comb begin
        locked = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            locked[i] = (stable_q[i] == StableC);
        end
    end

    assign sel          = sel_q;
    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign timeout_err  = tmo_q;

endmodule
